// File: rtl/temporal_align_pkg.sv
// Shared definitions for the temporal alignment blocks: timestamp width,
// interpolator FSM states, accept-time routing and packet field helper.
package temporal_align_pkg;

  localparam int TS_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    BLEND  = 2'd2,
    OUTPUT = 2'd3
  } interp_state_e;

  // Where an accepted pair goes, decided from its timestamps alone
  typedef enum logic [1:0] {
    ROUTE_ERROR  = 2'd0,
    ROUTE_W_ZERO = 2'd1,
    ROUTE_W_ONE  = 2'd2,
    ROUTE_DIVIDE = 2'd3
  } interp_route_e;

  // The timestamp field sits directly above the payload in every packet
  function automatic int ts_lsb(input int data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/interp_divider.sv
// Serial restoring divider producing the fractional interpolation weight.
// The caller guarantees dividend < divisor, so the quotient is a pure
// fraction of FRAC_BITS bits, one bit resolved per cycle, MSB first.
// done is high during the cycle of the final iteration; quotient then
// already includes the last bit so the caller can capture it on that edge.
module interp_divider
  import temporal_align_pkg::*;
#(
  parameter int FRAC_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [TS_WIDTH-1:0]  dividend,
  input  logic [TS_WIDTH-1:0]  divisor,
  output logic                 busy,
  output logic                 done,
  output logic [FRAC_BITS-1:0] quotient
);

  localparam int CNT_W = $clog2(FRAC_BITS + 1);

  logic [TS_WIDTH:0]    rem_q;
  logic [TS_WIDTH:0]    rem_shift;
  logic [TS_WIDTH:0]    rem_next;
  logic [TS_WIDTH-1:0]  div_q;
  logic [FRAC_BITS-1:0] quo_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 fits;

  // Remainder stays below the divisor, so dropping its top bit on shift is lossless
  assign rem_shift = (TS_WIDTH + 1)'({rem_q, 1'b0});
  assign fits      = rem_shift >= {1'b0, div_q};
  assign rem_next  = fits ? (rem_shift - {1'b0, div_q}) : rem_shift;
  assign quotient  = FRAC_BITS'({quo_q, fits});
  assign done      = busy && (cnt_q == CNT_W'(1));

  // Load operands on start, then iterate exactly FRAC_BITS times
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      div_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      rem_q <= {1'b0, dividend};
      div_q <= divisor;
      quo_q <= '0;
      cnt_q <= CNT_W'(FRAC_BITS);
      busy  <= 1'b1;
    end else if (busy) begin
      rem_q <= rem_next;
      quo_q <= quotient;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/temporal_interpolator.sv
// Linear interpolation of a packet payload between two timestamped samples.
// Build option: define INTERP_CLAMP_EN to clamp out-of-range targets to the
// nearest sample instead of flagging them as errors (t2 < t1 is always an error).
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE (and never while rst_n is low); out_valid is
// high only in OUTPUT and out_packet/out_error hold steady until out_ready.
module temporal_interpolator
  import temporal_align_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int LANE_WIDTH = 16,
  parameter int FRAC_BITS  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [TS_WIDTH-1:0]          t_common,
  input  logic [DATA_WIDTH+TS_WIDTH-1:0] packet1,
  input  logic [DATA_WIDTH+TS_WIDTH-1:0] packet2,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH+TS_WIDTH-1:0] out_packet,
  output logic                         out_error,
  output interp_state_e                fsm_state
);

  localparam int LANES  = DATA_WIDTH / LANE_WIDTH;
  localparam int TS_LSB = ts_lsb(DATA_WIDTH);
  localparam int PROD_W = LANE_WIDTH + FRAC_BITS + 3;
  localparam logic [FRAC_BITS:0] W_ONE = (FRAC_BITS + 1)'(1) << FRAC_BITS;

  interp_state_e state, state_next;
  interp_route_e route;

  logic [TS_WIDTH-1:0]   t1, t2;
  logic [TS_WIDTH-1:0]   tc_q;
  logic [DATA_WIDTH-1:0] pay1_q, pay2_q, blend_pay;
  logic [FRAC_BITS:0]    w_q;
  logic                  accept, div_start, div_busy, div_done;
  logic [FRAC_BITS-1:0]  div_quotient;
  logic                  out_error_q;
  logic [DATA_WIDTH+TS_WIDTH-1:0] out_packet_q;

  assign t1        = packet1[TS_LSB +: TS_WIDTH];
  assign t2        = packet2[TS_LSB +: TS_WIDTH];
  assign accept    = (state == IDLE) && in_valid;
  assign div_start = accept && (route == ROUTE_DIVIDE);
  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == OUTPUT);
  assign out_error = out_error_q;
  assign out_packet = out_packet_q;
  assign fsm_state = state;

  // Classify the offered pair by its timestamps
  always_comb begin
    route = ROUTE_DIVIDE;
    if (t2 < t1) begin
      route = ROUTE_ERROR;
    end else if ((t_common < t1) || (t_common > t2)) begin
`ifdef INTERP_CLAMP_EN
      route = (t_common < t1) ? ROUTE_W_ZERO : ROUTE_W_ONE;
`else
      route = ROUTE_ERROR;
`endif
    end else if (t_common == t1) begin
      route = ROUTE_W_ZERO;
    end else if (t_common == t2) begin
      route = ROUTE_W_ONE;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          case (route)
            ROUTE_ERROR:  state_next = OUTPUT;
            ROUTE_DIVIDE: state_next = DIVIDE;
            default:      state_next = BLEND;
          endcase
        end
      end
      DIVIDE: begin
        if (div_done)       state_next = BLEND;
        else if (!div_busy) state_next = IDLE;
      end
      BLEND:   state_next = OUTPUT;
      OUTPUT:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  interp_divider #(.FRAC_BITS(FRAC_BITS)) u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (t_common - t1),
    .divisor  (t2 - t1),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  // Per-lane blend: y = a + ((b - a) * w >>> FRAC_BITS), result always between a and b
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [LANE_WIDTH-1:0]  a, b;
    logic signed [LANE_WIDTH:0]    d;
    logic signed [FRAC_BITS+1:0]   w_s;
    logic signed [PROD_W-1:0]      prod;
    assign a    = pay1_q[i*LANE_WIDTH +: LANE_WIDTH];
    assign b    = pay2_q[i*LANE_WIDTH +: LANE_WIDTH];
    assign d    = (LANE_WIDTH + 1)'(b) - (LANE_WIDTH + 1)'(a);
    assign w_s  = {1'b0, w_q};
    assign prod = PROD_W'(d) * PROD_W'(w_s);
    assign blend_pay[i*LANE_WIDTH +: LANE_WIDTH] =
      LANE_WIDTH'(PROD_W'(a) + (prod >>> FRAC_BITS));
  end

  // Capture operands on accept, weight on divide completion, result in BLEND
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tc_q         <= '0;
      pay1_q       <= '0;
      pay2_q       <= '0;
      w_q          <= '0;
      out_packet_q <= '0;
      out_error_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tc_q   <= t_common;
            pay1_q <= packet1[DATA_WIDTH-1:0];
            pay2_q <= packet2[DATA_WIDTH-1:0];
            w_q    <= (route == ROUTE_W_ONE) ? W_ONE : '0;
            if (route == ROUTE_ERROR) begin
              out_packet_q <= {t_common, packet1[DATA_WIDTH-1:0]};
              out_error_q  <= 1'b1;
            end
          end
        end
        DIVIDE: if (div_done) w_q <= {1'b0, div_quotient};
        BLEND: begin
          out_packet_q <= {tc_q, blend_pay};
          out_error_q  <= 1'b0;
        end
        OUTPUT: if (out_ready) out_error_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
